// File: rtl/vc_output_arbiter_pkg.sv
// +----------------------------------------------------------------------------+
// | Module   : vc_output_arbiter_pkg                                           |
// | Purpose  : Shared types and defaults for the per-output-port VC scheduler: |
// |            VC id and credit counter types, lock state encoding, and a     |
// |            helper for the minimum-1 id width.                             |
// | Ports    : none (package)                                                  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
`default_nettype none

`ifndef FLIT_DATA_WIDTH
`define FLIT_DATA_WIDTH 32
`endif

package vc_output_arbiter_pkg;

  // Width of an index into n items, never narrower than one bit.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int NUM_VC_DEFAULT       = 4;
  localparam int BUFFER_DEPTH_DEFAULT = 8;
  localparam int DATA_WIDTH_DEFAULT   = `FLIT_DATA_WIDTH;
  localparam int VC_ID_WIDTH_DEFAULT  = id_width(NUM_VC_DEFAULT);
  localparam int CREDIT_WIDTH_DEFAULT = $clog2(BUFFER_DEPTH_DEFAULT) + 1;

  typedef logic [VC_ID_WIDTH_DEFAULT-1:0]  vc_id_t;
  typedef logic [CREDIT_WIDTH_DEFAULT-1:0] credit_t;

  // Wormhole lock: FREE lets any eligible VC win, HELD pins grants to one VC.
  typedef enum logic [0:0] {
    LOCK_FREE = 1'b0,
    LOCK_HELD = 1'b1
  } lock_state_t;

endpackage

`default_nettype wire

// File: rtl/vc_output_arbiter_if.sv
// +----------------------------------------------------------------------------+
// | Module   : vc_output_arbiter_if                                            |
// | Purpose  : Bundle between the input VC fifos / downstream credit path and  |
// |            the output arbiter.                                             |
// | Signals  : vc_empty, vc_tail, vc_data, credit_return  (fifo/link -> arb)  |
// |            vc_pop, out_valid, out_vc, out_data, credit_err (arb -> rest)  |
// | Modports : master = fifo/link side, slave = arbiter side                   |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
`default_nettype none

interface vc_output_arbiter_if #(
  parameter int NUM_VC      = 4,
  parameter int DATA_WIDTH  = 32,
  parameter int VC_ID_WIDTH = 2
);

  logic [NUM_VC-1:0]            vc_empty;
  logic [NUM_VC-1:0]            vc_tail;
  logic [NUM_VC*DATA_WIDTH-1:0] vc_data;
  logic [NUM_VC-1:0]            credit_return;
  logic [NUM_VC-1:0]            vc_pop;
  logic                         out_valid;
  logic [VC_ID_WIDTH-1:0]       out_vc;
  logic [DATA_WIDTH-1:0]        out_data;
  logic                         credit_err;

  modport master (
    output vc_empty, vc_tail, vc_data, credit_return,
    input  vc_pop, out_valid, out_vc, out_data, credit_err
  );

  modport slave (
    input  vc_empty, vc_tail, vc_data, credit_return,
    output vc_pop, out_valid, out_vc, out_data, credit_err
  );

endinterface

`default_nettype wire

// File: rtl/vc_output_arbiter_rr_arbiter.sv
// +----------------------------------------------------------------------------+
// | Module   : vc_output_arbiter_rr_arbiter                                    |
// | Purpose  : Combinational rotating-priority picker. The first requester at |
// |            or after ptr (wrapping at NUM_VC) wins.                         |
// | Ports    : req       in  NUM_VC       request vector                      |
// |            ptr       in  VC_ID_WIDTH  highest-priority index              |
// |            grant     out NUM_VC       one-hot-or-zero grant               |
// |            grant_idx out VC_ID_WIDTH  index of the granted requester      |
// |            grant_any out 1            some requester won                  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
`default_nettype none

module vc_output_arbiter_rr_arbiter #(
  parameter int NUM_VC      = 4,
  parameter int VC_ID_WIDTH = 2
) (
  input  wire logic [NUM_VC-1:0]      req,
  input  wire logic [VC_ID_WIDTH-1:0] ptr,
  output logic      [NUM_VC-1:0]      grant,
  output logic      [VC_ID_WIDTH-1:0] grant_idx,
  output logic                        grant_any
);

  always_comb begin
    int k;
    k         = 0;
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    // Walk offsets from farthest to nearest so the nearest requester to ptr
    // is the last one written and therefore wins.
    for (int i = NUM_VC - 1; i >= 0; i--) begin
      k = int'(ptr) + i;
      if (k >= NUM_VC) begin
        k = k - NUM_VC;
      end
      if (req[k]) begin
        grant     = '0;
        grant[k]  = 1'b1;
        grant_idx = VC_ID_WIDTH'(k);
        grant_any = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/vc_output_arbiter.sv
// +----------------------------------------------------------------------------+
// | Module   : vc_output_arbiter                                               |
// | Purpose  : Per-output-port scheduler. Each cycle grants one eligible VC    |
// |            (non-empty and holding downstream credit) in round-robin order,|
// |            pops its fifo and registers the flit onto the output link.     |
// |            Tracks per-VC downstream credits returned by the next hop.     |
// | Ports    : clk, reset (synchronous, active high)                           |
// |            bus (vc_output_arbiter_if.slave):                               |
// |              vc_empty/vc_tail/vc_data/credit_return in                     |
// |              vc_pop (combinational), out_valid/out_vc/out_data            |
// |              (registered), credit_err (sticky)                            |
// | Config   : ARB_PACKET_LOCK_EN - wormhole lock; a granted non-tail flit    |
// |            pins arbitration to its VC until that VC's tail is granted.    |
// |            Undefined: per-flit round robin, vc_tail ignored.              |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
`default_nettype none

module vc_output_arbiter
  import vc_output_arbiter_pkg::*;
#(
  parameter int NUM_VC       = NUM_VC_DEFAULT,
  parameter int DATA_WIDTH   = DATA_WIDTH_DEFAULT,
  parameter int BUFFER_DEPTH = 4,
  parameter int VC_ID_WIDTH  = id_width(NUM_VC),
  parameter int CREDIT_WIDTH = $clog2(BUFFER_DEPTH) + 1
) (
  input wire logic          clk,
  input wire logic          reset,
  vc_output_arbiter_if.slave bus
);

  localparam logic [CREDIT_WIDTH-1:0] FULL_CREDIT = CREDIT_WIDTH'(BUFFER_DEPTH);
  localparam logic [VC_ID_WIDTH-1:0]  LAST_VC     = VC_ID_WIDTH'(NUM_VC - 1);

  logic [CREDIT_WIDTH-1:0] credit [NUM_VC];
  logic [NUM_VC-1:0]       elig;
  logic [NUM_VC-1:0]       req;
  logic [NUM_VC-1:0]       grant;
  logic [NUM_VC-1:0]       ret_overflow;
  logic [VC_ID_WIDTH-1:0]  rr_ptr;
  logic [VC_ID_WIDTH-1:0]  grant_idx;
  logic                    grant_any;

  genvar v;
  generate
    for (v = 0; v < NUM_VC; v++) begin : g_elig
      assign elig[v] = !bus.vc_empty[v] && (credit[v] != '0);
      // A return with no matching grant while already full means the
      // downstream handed back a slot it never had.
      assign ret_overflow[v] = bus.credit_return[v] && !grant[v] &&
                               (credit[v] == FULL_CREDIT);
    end
  endgenerate

`ifdef ARB_PACKET_LOCK_EN
  lock_state_t            lock_state;
  logic [VC_ID_WIDTH-1:0] lock_vc;
  logic [NUM_VC-1:0]      lock_mask;

  always_comb begin
    lock_mask = '1;
    if (lock_state == LOCK_HELD) begin
      lock_mask          = '0;
      lock_mask[lock_vc] = 1'b1;
    end
  end

  assign req = elig & lock_mask;

  // Lock follows the granted flit: non-tail grabs (or keeps) the lock,
  // tail releases it on the same edge. No grant leaves it untouched.
  always_ff @(posedge clk) begin
    if (reset) begin
      lock_state <= LOCK_FREE;
      lock_vc    <= '0;
    end else if (grant_any) begin
      if (bus.vc_tail[grant_idx]) begin
        lock_state <= LOCK_FREE;
      end else begin
        lock_state <= LOCK_HELD;
        lock_vc    <= grant_idx;
      end
    end
  end
`else
  assign req = elig;
`endif

  vc_output_arbiter_rr_arbiter #(
    .NUM_VC      (NUM_VC),
    .VC_ID_WIDTH (VC_ID_WIDTH)
  ) u_rr (
    .req       (req),
    .ptr       (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  // Fifos must never see a pop while the router is held in reset.
  assign bus.vc_pop = reset ? '0 : grant;

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr        <= '0;
      bus.out_valid <= 1'b0;
      bus.out_vc    <= '0;
      bus.out_data  <= '0;
    end else begin
      bus.out_valid <= grant_any;
      if (grant_any) begin
        bus.out_vc   <= grant_idx;
        bus.out_data <= bus.vc_data[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
        rr_ptr       <= (grant_idx == LAST_VC) ? '0 : grant_idx + 1'b1;
      end
    end
  end

  // A grant consumes a downstream slot, a return frees one; both in the same
  // cycle cancel. Returns at full credit saturate and flag credit_err.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_VC; i++) begin
      if (reset) begin
        credit[i] <= FULL_CREDIT;
      end else if (grant[i] && !bus.credit_return[i]) begin
        credit[i] <= credit[i] - 1'b1;
      end else if (bus.credit_return[i] && !grant[i] && (credit[i] != FULL_CREDIT)) begin
        credit[i] <= credit[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.credit_err <= 1'b0;
    end else if (|ret_overflow) begin
      bus.credit_err <= 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_vc_output_arbiter.sv
// +----------------------------------------------------------------------------+
// | Module   : tb_vc_output_arbiter                                            |
// | Purpose  : Self-checking bench for vc_output_arbiter (4 VCs, depth 4,     |
// |            8-bit flits). Directed scenarios with literal expectations,    |
// |            then randomized traffic against a behavioural model.           |
// | Config   : ARB_PACKET_LOCK_EN selects the wormhole-lock expectations.     |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_vc_output_arbiter;

  localparam int NV = 4;
  localparam int DW = 8;
  localparam int BD = 4;
`ifdef ARB_PACKET_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic clk   = 1'b0;
  logic reset = 1'b1;

  vc_output_arbiter_if #(.NUM_VC(NV), .DATA_WIDTH(DW), .VC_ID_WIDTH(2)) bus ();

  vc_output_arbiter #(
    .NUM_VC       (NV),
    .DATA_WIDTH   (DW),
    .BUFFER_DEPTH (BD)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int  m_cred [NV];
  int  m_ptr;
  int  m_lock;      // -1 when no packet holds the port
  bit  m_valid;
  int  m_vc;
  int  m_data;
  bit  m_err;
  bit  model_on = 1'b0;
  int  mg;

  function automatic int pick();
    for (int i = 0; i < NV; i++) begin
      int c;
      c = (m_ptr + i) % NV;
      if (!bus.vc_empty[c] && m_cred[c] > 0 && (!LOCK_EN || m_lock < 0 || m_lock == c))
        return c;
    end
    return -1;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NV; i++) m_cred[i] = BD;
      m_ptr = 0; m_lock = -1; m_valid = 0; m_vc = 0; m_data = 0; m_err = 0;
      model_on = 1'b1;
    end else begin
      mg = pick();
      m_valid = (mg >= 0);
      if (mg >= 0) begin
        m_vc   = mg;
        m_data = int'(bus.vc_data[mg*DW +: DW]);
        m_ptr  = (mg + 1) % NV;
        m_lock = bus.vc_tail[mg] ? -1 : mg;
      end
      for (int i = 0; i < NV; i++) begin
        if (mg == i && !bus.credit_return[i]) m_cred[i] = m_cred[i] - 1;
        else if (bus.credit_return[i] && mg != i) begin
          if (m_cred[i] == BD) m_err = 1;
          else m_cred[i] = m_cred[i] + 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (model_on) begin
      logic [NV-1:0] ep;
      int g;
      ep = '0;
      g  = -1;
      if (!reset) g = pick();
      if (g >= 0) ep[g] = 1'b1;
      check("model vc_pop", longint'(bus.vc_pop), longint'(ep));
      check("model out_valid", longint'(bus.out_valid), longint'(m_valid));
      check("model out_vc", longint'(bus.out_vc), longint'(m_vc));
      check("model out_data", longint'(bus.out_data), longint'(m_data));
      check("model credit_err", longint'(bus.credit_err), longint'(m_err));
      for (int i = 0; i < NV; i++)
        check($sformatf("model credit[%0d]", i), longint'(dut.credit[i]), longint'(m_cred[i]));
    end
  end

  // ---------------- directed helpers ----------------
  logic [NV-1:0] last_pop;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step_pop(input string name, input logic [NV-1:0] exp);
    @(negedge clk);
    check(name, longint'(bus.vc_pop), longint'(exp));
    last_pop = bus.vc_pop;
    tick();
  endtask

  task automatic step_out(input string name, input logic [NV-1:0] ep, input logic ov,
                          input logic [1:0] ovc, input logic [DW-1:0] od);
    @(negedge clk);
    check({name, " pop"},   longint'(bus.vc_pop),    longint'(ep));
    check({name, " valid"}, longint'(bus.out_valid), longint'(ov));
    check({name, " vc"},    longint'(bus.out_vc),    longint'(ovc));
    check({name, " data"},  longint'(bus.out_data),  longint'(od));
    tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  logic [NV-1:0] exp6 [5];
  int            n6;
  int            f0;

  initial begin
    bus.vc_empty      = '1;
    bus.vc_tail       = '0;
    bus.vc_data       = '0;
    bus.credit_return = '0;

    // 1: reset with every VC non-empty
    bus.vc_empty = '0;
    tick();
    tick();
    @(negedge clk);
    check("rst vc_pop", longint'(bus.vc_pop), 0);
    check("rst out_valid", longint'(bus.out_valid), 0);
    check("rst credit_err", longint'(bus.credit_err), 0);
    for (int i = 0; i < NV; i++)
      check($sformatf("rst credit[%0d]", i), longint'(dut.credit[i]), BD);
    tick();
    reset = 1'b0;

    // 2: all non-empty, rotating grants with 1-cycle output latency
    for (int i = 0; i < NV; i++) bus.vc_data[i*DW +: DW] = DW'(8'hA0 + i);
    step_out("rr0", 4'b0001, 1'b0, 2'd0, 8'h00);
    step_out("rr1", 4'b0010, 1'b1, 2'd0, 8'hA0);
    step_out("rr2", 4'b0100, 1'b1, 2'd1, 8'hA1);
    step_out("rr3", 4'b1000, 1'b1, 2'd2, 8'hA2);
    step_out("rr4", 4'b0001, 1'b1, 2'd3, 8'hA3);

    // 3: only VC2, credits run out, one return gives one more grant
    bus.vc_empty = 4'b1011;
    do_reset();
    for (int i = 0; i < BD; i++) step_pop("vc2 drain", 4'b0100);
    step_pop("vc2 stall", 4'b0000);
    bus.credit_return = 4'b0100;
    step_pop("vc2 ret cycle", 4'b0000);
    bus.credit_return = 4'b0000;
    step_pop("vc2 regrant", 4'b0100);
    step_pop("vc2 stall again", 4'b0000);

    // 4: VC1 at credit 1, grant and return together keep the count
    bus.vc_empty = 4'b1101;
    do_reset();
    for (int i = 0; i < BD - 1; i++) step_pop("vc1 drain", 4'b0010);
    bus.credit_return = 4'b0010;
    step_pop("vc1 grant+ret", 4'b0010);
    bus.credit_return = 4'b0000;
    @(negedge clk);
    check("vc1 credit kept", longint'(dut.credit[1]), 1);
    tick();
    step_pop("vc1 after", 4'b0000);

    // 5: return at full credit sets sticky error
    bus.vc_empty = '1;
    do_reset();
    bus.credit_return = 4'b1000;
    @(negedge clk);
    check("err before", longint'(bus.credit_err), 0);
    tick();
    bus.credit_return = 4'b0000;
    @(negedge clk);
    check("err set", longint'(bus.credit_err), 1);
    check("err credit[3]", longint'(dut.credit[3]), BD);
    tick();
    tick();
    tick();
    @(negedge clk);
    check("err sticky", longint'(bus.credit_err), 1);
    tick();
    reset = 1'b1;
    tick();
    @(negedge clk);
    check("err cleared", longint'(bus.credit_err), 0);
    tick();
    reset = 1'b0;

    // 6: 3-flit packet on VC0 competing with VC1
`ifdef ARB_PACKET_LOCK_EN
    exp6[0] = 4'b0001; exp6[1] = 4'b0001; exp6[2] = 4'b0001; exp6[3] = 4'b0010;
    exp6[4] = 4'b0000;
    n6 = 4;
`else
    exp6[0] = 4'b0001; exp6[1] = 4'b0010; exp6[2] = 4'b0001; exp6[3] = 4'b0010;
    exp6[4] = 4'b0001;
    n6 = 5;
`endif
    bus.vc_empty = 4'b1100;
    bus.vc_tail  = '0;
    do_reset();
    f0 = 0;
    for (int i = 0; i < n6; i++) begin
      bus.vc_tail[0] = (f0 % 3 == 2);
      step_pop($sformatf("pkt grant %0d", i), exp6[i]);
      if (last_pop[0]) f0++;
    end

    // Randomized traffic checked by the model every cycle
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NV; i++) begin
        bus.vc_empty[i]      = ($urandom_range(0, 3) == 0);
        bus.vc_tail[i]       = ($urandom_range(0, 2) == 0);
        bus.vc_data[i*DW +: DW] = DW'($urandom);
        bus.credit_return[i] = ($urandom_range(0, 2) == 0) &&
                               (m_cred[i] < BD || $urandom_range(0, 63) == 0);
      end
      reset = ($urandom_range(0, 299) == 0);
      tick();
    end
    reset = 1'b0;
    bus.credit_return = '0;
    tick();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
